// File: rtl/obstacle_spawner_n.sv
// -----------------------------------------------------------------------------
// obstacle_spawner_n
//
// Keeps NUM_OBS obstacle slots that scroll toward x = 0 by i_speed on every
// valid game tick. A slot that would pass x = 0 leaves the screen. When the
// spawn countdown has expired, a new obstacle is placed at GEN_LINE in the
// lowest free slot.
//
// Ports:
//   clk            single clock
//   rst            synchronous active-high reset; overrides everything else
//   i_game_tick    one-cycle game-update strobe
//   i_run          game running; ticks are ignored while low
//   i_clear        one-cycle pulse that empties every slot for a new game
//   i_speed        pixels per tick in converted units (0..7)
//   i_rng          free-running random byte (type and gap jitter come from it)
//   o_obs_pos      packed slot positions, slot k at [k*POS_W +: POS_W]
//   o_obs_type     packed slot types, slot k at [k*3 +: 3]
//   o_obs_active   bit k set when slot k holds an obstacle
//   o_spawn_pulse  registered: a slot was filled by the previous valid tick
//   o_pass_pulse   registered: one or more obstacles left on the previous tick
// -----------------------------------------------------------------------------
module obstacle_spawner_n #(
  parameter int NUM_OBS       = 3,
  parameter int CONV          = 2,
  parameter int GEN_LINE      = 250,
  parameter int MIN_GAP_TICKS = 30,
  localparam int POS_W        = 10 - CONV
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_game_tick,
  input  logic                       i_run,
  input  logic                       i_clear,
  input  logic [2:0]                 i_speed,
  input  logic [7:0]                 i_rng,
  output logic [NUM_OBS*POS_W-1:0]   o_obs_pos,
  output logic [NUM_OBS*3-1:0]       o_obs_type,
  output logic [NUM_OBS-1:0]         o_obs_active,
  output logic                       o_spawn_pulse,
  output logic                       o_pass_pulse
);

  localparam logic [POS_W-1:0] GEN_POS = POS_W'(GEN_LINE);
  localparam logic [7:0]       MIN_GAP = 8'(MIN_GAP_TICKS);

  logic [POS_W-1:0] pos_q  [NUM_OBS];
  logic [POS_W-1:0] pos_d  [NUM_OBS];
  logic [2:0]       type_q [NUM_OBS];
  logic [2:0]       type_d [NUM_OBS];
  logic [NUM_OBS-1:0] active_q;
  logic [NUM_OBS-1:0] active_d;
  logic [7:0]       gap_cnt;
  logic [7:0]       gap_cnt_d;
  logic             spawn_q;
  logic             spawn_d;
  logic             pass_q;
  logic             pass_d;
  logic             valid_tick;
  logic             found;
  logic [POS_W-1:0] speed_ext;

  // Only the low nibble and bits [6:4] of the random byte are consumed.
  logic unused_rng_bit;
  assign unused_rng_bit = i_rng[7];

  assign valid_tick = i_game_tick & i_run & ~i_clear;
  assign speed_ext  = POS_W'(i_speed);

  // Next-state logic. The spawn decision looks only at active_q (occupancy
  // at tick start), so a slot freed by an exit on this tick is not refilled
  // until the following tick, and a freshly spawned slot is never moved.
  always_comb begin
    pos_d     = pos_q;
    type_d    = type_q;
    active_d  = active_q;
    gap_cnt_d = gap_cnt;
    spawn_d   = 1'b0;
    pass_d    = 1'b0;
    found     = 1'b0;

    if (i_clear) begin
      active_d  = '0;
      for (int k = 0; k < NUM_OBS; k++) pos_d[k] = '0;
      gap_cnt_d = MIN_GAP;
    end else if (valid_tick) begin
      for (int k = 0; k < NUM_OBS; k++) begin
        if (active_q[k]) begin
          if (pos_q[k] >= speed_ext) begin
            pos_d[k] = pos_q[k] - speed_ext;
          end else begin
            active_d[k] = 1'b0;
            pos_d[k]    = '0;
            pass_d      = 1'b1;
          end
        end
      end

      if (gap_cnt != 8'd0) begin
        gap_cnt_d = gap_cnt - 8'd1;
      end else if (!(&active_q)) begin
        spawn_d   = 1'b1;
        gap_cnt_d = MIN_GAP + {4'd0, i_rng[3:0]};
        // Lowest-index free slot wins.
        for (int k = 0; k < NUM_OBS; k++) begin
          if (!active_q[k] && !found) begin
            found       = 1'b1;
            active_d[k] = 1'b1;
            pos_d[k]    = GEN_POS;
            type_d[k]   = i_rng[6:4];
          end
        end
      end
    end
  end

  // State register. Reset discards any tick presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_OBS; k++) begin
        pos_q[k]  <= '0;
        type_q[k] <= '0;
      end
      active_q <= '0;
      gap_cnt  <= MIN_GAP;
      spawn_q  <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_OBS; k++) begin
        pos_q[k]  <= pos_d[k];
        type_q[k] <= type_d[k];
      end
      active_q <= active_d;
      gap_cnt  <= gap_cnt_d;
      spawn_q  <= spawn_d;
      pass_q   <= pass_d;
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
    assign o_obs_pos[g*POS_W +: POS_W] = pos_q[g];
    assign o_obs_type[g*3 +: 3]        = type_q[g];
  end

  assign o_obs_active  = active_q;
  assign o_spawn_pulse = spawn_q;
  assign o_pass_pulse  = pass_q;

endmodule

// File: doc/obstacle_spawner_n.md
OBSTACLE_SPAWNER_N -- requirements
Module: obstacle_spawner_n

Interface
REQ-001 The block SHALL have parameter NUM_OBS, default 3: number of obstacle slots, 1 to 8.
REQ-002 The block SHALL have parameter CONV, default 2: position scaling shift; POS_W = 10-CONV.
REQ-003 The block SHALL have parameter GEN_LINE, default 250: spawn x-position, which must fit in POS_W bits.
REQ-004 The block SHALL have parameter MIN_GAP_TICKS, default 30: minimum ticks between spawns, which must fit in 8 bits together with +15.
REQ-005 The block SHALL have port clk, input, 1: the single clock.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port i_game_tick, input, 1: one-cycle game-update strobe.
REQ-008 The block SHALL have port i_run, input, 1: game running; when low, ticks are ignored.
REQ-009 The block SHALL have port i_clear, input, 1: one-cycle pulse that empties all slots, for a new game.
REQ-010 The block SHALL have port i_speed, input, 3: pixels per tick in converted units, 0 to 7.
REQ-011 The block SHALL have port i_rng, input, 8: free-running random byte.
REQ-012 The block SHALL have port o_obs_pos, output, NUM_OBS*POS_W: slot k at bits [k*POS_W +: POS_W].
REQ-013 The block SHALL have port o_obs_type, output, NUM_OBS*3: slot k at bits [k*3 +: 3].
REQ-014 The block SHALL have port o_obs_active, output, NUM_OBS: bit k set means slot k is occupied.
REQ-015 The block SHALL have port o_spawn_pulse, output, 1: a slot was filled this update.
REQ-016 The block SHALL have port o_pass_pulse, output, 1: one or more obstacles left the screen this update.

Function
REQ-017 Processing SHALL occur only in a cycle with i_game_tick=1, i_run=1 and i_clear=0 (a "valid tick"); all outputs SHALL change one cycle after the valid tick.
REQ-018 On a valid tick, each active slot with pos >= i_speed SHALL update to pos = pos - i_speed and stay active.
REQ-019 On a valid tick, each active slot with pos < i_speed SHALL clear its active bit and set pos to 0; o_pass_pulse SHALL be 1 for exactly one cycle, even if several slots exit together.
REQ-020 Boundary: pos == i_speed SHALL give pos 0, still active; the slot exits on the next valid tick if i_speed > 0.
REQ-021 i_speed = 0: positions SHALL hold and no slot SHALL exit; spawn countdown SHALL still run.
REQ-022 The block SHALL have an 8-bit spawn countdown register gap_cnt.
REQ-023 On a valid tick with gap_cnt > 0, gap_cnt SHALL decrement by 1.
REQ-024 On a valid tick with gap_cnt == 0 and at least one slot free at the start of the tick, the block SHALL spawn into the lowest-index free slot.
REQ-025 On spawn: active=1, pos=GEN_LINE, type=i_rng[6:4], gap_cnt=MIN_GAP_TICKS + i_rng[3:0], and o_spawn_pulse=1 for one cycle.
REQ-026 A spawned slot SHALL NOT move on its spawn tick.
REQ-027 With gap_cnt == 0 and all slots active at tick start, there SHALL be no spawn and gap_cnt SHALL hold at 0.
REQ-028 A slot freed by an exit on tick T SHALL be spawnable from tick T+1, not on tick T.
REQ-029 Spawning SHALL only ever fill a slot that was free at tick start, so at most one spawn occurs per tick.
REQ-030 i_clear=1 SHALL take priority over a simultaneous tick: it clears all active bits and positions to 0, sets gap_cnt=MIN_GAP_TICKS, and produces no pulses.
REQ-031 Types SHALL be held unchanged on exit and on clear; they are don't-care when inactive.
REQ-032 With i_run=0, all state SHALL hold and pulses SHALL be 0; i_clear SHALL still act.
REQ-033 o_spawn_pulse and o_pass_pulse SHALL both be registered and SHALL be 0 in every cycle except the one following a valid tick.

Reset
REQ-034 While rst=1 at a clk edge: o_obs_active=0, o_obs_pos=0, o_obs_type=0, gap_cnt=MIN_GAP_TICKS, and both pulses 0.
REQ-035 rst SHALL override i_clear and i_game_tick; reset mid-tick SHALL discard that tick.

Verification (defaults NUM_OBS=3, CONV=2, POS_W=8, GEN_LINE=250, MIN_GAP_TICKS=30)
REQ-036 Reset then 30 valid ticks at speed 2 -> no spawn. Tick 31 with i_rng=8'h5A -> slot0 active, pos 250, type 5, gap_cnt 40, o_spawn_pulse high for 1 cycle.
REQ-037 Slot0 at pos 250, speed 3, one valid tick -> pos 247 one cycle later. Then pos 3, speed 3 -> pos 0, still active. Next tick -> inactive, o_pass_pulse=1 for 1 cycle.
REQ-038 All 3 slots active, gap_cnt 0, slot1 at pos 2, speed 3, tick T -> slot1 exits, no spawn. Tick T+1 -> spawn into slot1.
REQ-039 i_clear and i_game_tick asserted in the same cycle with slots active -> all inactive, pos 0, gap_cnt 30, no pulses.
REQ-040 i_run=0 for 10 ticks -> outputs and gap_cnt unchanged; then i_run=1 -> processing resumes from the held values.
REQ-041 rst asserted during a valid-tick cycle with 2 slots active -> the cycle after, all outputs 0 and the first spawn occurs on the 31st valid tick.
